// File: rtl/my_pe_pkg.sv
// Shared types and helpers for the my_pe_v2 processing element.
package my_pe_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_RUN,
    ST_DRAIN,
    ST_DONE
  } state_t;

  // Accumulator width that holds 2**l_ram products of two size-bit operands.
  function automatic int unsigned acc_width(input int unsigned size, input int unsigned l_ram);
    return 2 * size + l_ram;
  endfunction

  // Clamp a signed value to the signed range of a w-bit result.
  function automatic longint sat_signed(input longint x, input int unsigned w);
    longint hi;
    longint lo;
    hi = (64'sd1 <<< (w - 1)) - 64'sd1;
    lo = -(64'sd1 <<< (w - 1));
    if (x > hi) return hi;
    if (x < lo) return lo;
    return x;
  endfunction

endpackage

// File: rtl/my_pe_v2_if.sv
// Weight-load and activation-stream bus between the controller and a my_pe_v2.
interface my_pe_v2_if #(
  parameter int unsigned SIZE       = 8,
  parameter int unsigned L_RAM_SIZE = 3,
  parameter int unsigned OUT_W      = 16
);
  logic                  we;
  logic [L_RAM_SIZE-1:0] addr;
  logic [SIZE-1:0]       din;
  logic                  start;
  logic [L_RAM_SIZE:0]   len;
  logic                  accum;
  logic [SIZE-1:0]       ain;
  logic                  valid;
  logic                  ready;
  logic                  busy;
  logic                  dvalid;
  logic [OUT_W-1:0]      dout;

  modport master (
    output we, addr, din, start, len, accum, ain, valid,
    input  ready, busy, dvalid, dout
  );

  modport slave (
    input  we, addr, din, start, len, accum, ain, valid,
    output ready, busy, dvalid, dout
  );
endinterface

// File: rtl/my_pe_mac.sv
// Pipelined signed MAC: operand registers -> product register -> accumulator.
module my_pe_mac #(
  parameter int unsigned SIZE  = 8,
  parameter int unsigned ACC_W = 19
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    clr,
  input  logic                    load,
  input  logic signed [SIZE-1:0]  a,
  input  logic signed [SIZE-1:0]  b,
  output logic signed [ACC_W-1:0] acc
);
  localparam int unsigned PW = 2 * SIZE;

  logic signed [SIZE-1:0] a_q;
  logic signed [SIZE-1:0] b_q;
  logic signed [PW-1:0]   prod;
  logic                   a_vld;
  logic                   p_vld;

  // Valid bits follow each term so stalls never add stale products.
  always_ff @(posedge clk) begin
    if (rst) begin
      a_q   <= '0;
      b_q   <= '0;
      prod  <= '0;
      a_vld <= 1'b0;
      p_vld <= 1'b0;
      acc   <= '0;
    end else begin
      a_vld <= load;
      if (load) begin
        a_q <= a;
        b_q <= b;
      end
      p_vld <= a_vld;
      prod  <= PW'(a_q) * PW'(b_q);
      if (clr)        acc <= '0;
      else if (p_vld) acc <= acc + ACC_W'(prod);
    end
  end

endmodule

// File: rtl/my_pe_v2.sv
// Processing element: weight RAM, job FSM and dot-product MAC with held result.
// Define MY_PE_V2_SAT_EN to saturate dout instead of truncating it.
module my_pe_v2
  import my_pe_pkg::*;
#(
  parameter int unsigned SIZE       = 8,
  parameter int unsigned L_RAM_SIZE = 3,
  parameter int unsigned OUT_W      = 16
) (
  input  logic       aclk,
  input  logic       areset,
  my_pe_v2_if.slave  bus
);
  localparam int unsigned DEPTH = 2 ** L_RAM_SIZE;
  localparam int unsigned CW    = L_RAM_SIZE + 1;
  localparam int unsigned ACC_W = acc_width(SIZE, L_RAM_SIZE);

  state_t                   state;
  state_t                   state_nxt;
  logic [SIZE-1:0]          peram [DEPTH];
  logic [CW-1:0]            idx;
  logic [CW-1:0]            len_q;
  logic [CW-1:0]            len_eff;
  logic                     drain_cnt;
  logic                     start_ok;
  logic                     fire;
  logic                     last_beat;
  logic                     mac_clr;
  logic                     dout_load;
  logic signed [ACC_W-1:0]  acc;

  assign start_ok  = (state == ST_IDLE) && bus.start;
  assign fire      = (state == ST_RUN) && bus.valid;
  assign last_beat = fire && (idx == len_q - CW'(1));
  assign len_eff   = ((bus.len == '0) || (bus.len > CW'(DEPTH))) ? CW'(DEPTH) : bus.len;

  always_ff @(posedge aclk) begin
    if (areset) state <= ST_IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE:  if (bus.start) state_nxt = ST_RUN;
      ST_RUN:   if (last_beat) state_nxt = ST_DRAIN;
      ST_DRAIN: if (drain_cnt) state_nxt = ST_DONE;
      ST_DONE:  state_nxt = ST_IDLE;
      default:  state_nxt = ST_IDLE;
    endcase
  end

  always_comb begin
    mac_clr   = 1'b0;
    dout_load = 1'b0;
    if (start_ok && !bus.accum) mac_clr = 1'b1;
    if (state == ST_DONE)       dout_load = 1'b1;
  end

  // Job bookkeeping: beat index, latched length, drain timer.
  always_ff @(posedge aclk) begin
    if (areset) begin
      idx       <= '0;
      len_q     <= CW'(DEPTH);
      drain_cnt <= 1'b0;
    end else begin
      drain_cnt <= (state == ST_DRAIN) ? ~drain_cnt : 1'b0;
      if (start_ok) begin
        idx   <= '0;
        len_q <= len_eff;
      end else if (fire) begin
        idx <= idx + CW'(1);
      end
    end
  end

  // Weight RAM is deliberately left out of reset so contents survive an abort.
  always_ff @(posedge aclk) begin
    if (bus.we && (state == ST_IDLE)) peram[bus.addr] <= bus.din;
  end

  my_pe_mac #(
    .SIZE  (SIZE),
    .ACC_W (ACC_W)
  ) u_mac (
    .clk  (aclk),
    .rst  (areset),
    .clr  (mac_clr),
    .load (fire),
    .a    (bus.ain),
    .b    (peram[idx[L_RAM_SIZE-1:0]]),
    .acc  (acc)
  );

  // Handshake/status flags are registered from the next state.
  always_ff @(posedge aclk) begin
    if (areset) begin
      bus.ready  <= 1'b0;
      bus.busy   <= 1'b0;
      bus.dvalid <= 1'b0;
      bus.dout   <= '0;
    end else begin
      bus.ready  <= (state_nxt == ST_RUN);
      bus.busy   <= (state_nxt != ST_IDLE);
      bus.dvalid <= dout_load;
      if (dout_load) begin
`ifdef MY_PE_V2_SAT_EN
        bus.dout <= OUT_W'(sat_signed(64'(acc), OUT_W));
`else
        bus.dout <= OUT_W'(acc);
`endif
      end
    end
  end

endmodule
